// File: rtl/jellyvl_arith_multicycle_pkg.sv
// Shared helpers for the multicycle arithmetic blocks (multiplier and divider).
package jellyvl_arith_multicycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mc_state_t;

    // Iteration counter width: clog2(n+1), never less than one bit.
    function automatic int unsigned cycle_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Full-precision width of a*b+c where c is no wider than a.
    function automatic int unsigned product_width(input int unsigned a_width, input int unsigned b_width);
        return a_width + b_width;
    endfunction

endpackage

// File: rtl/jellyvl_multiplier_unsigned_multicycle.sv
// Unsigned shift-add multiply-accumulate, one multiplier bit per cycle:
// m_product = s_multiplicand * s_multiplier + s_addend.
module jellyvl_multiplier_unsigned_multicycle
    import jellyvl_arith_multicycle_pkg::*;
#(
    parameter int unsigned MULTIPLICAND_WIDTH = 32,
    parameter int unsigned MULTIPLIER_WIDTH   = 32,
    parameter int unsigned ADDEND_WIDTH       = MULTIPLICAND_WIDTH,
    parameter int unsigned PRODUCT_WIDTH      = product_width(MULTIPLICAND_WIDTH, MULTIPLIER_WIDTH)
) (
    input  logic                          rst,
    input  logic                          clk,
    input  logic                          cke,

    input  logic [MULTIPLICAND_WIDTH-1:0] s_multiplicand,
    input  logic [MULTIPLIER_WIDTH-1:0]   s_multiplier,
    input  logic [ADDEND_WIDTH-1:0]       s_addend,
    input  logic                          s_valid,
    output logic                          s_ready,

    output logic [PRODUCT_WIDTH-1:0]      m_product,
    output logic                          m_valid,
    input  logic                          m_ready
);

    localparam int unsigned CYCLE_WIDTH = cycle_width(MULTIPLIER_WIDTH);
    localparam int unsigned SHIFT_WIDTH = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
    localparam int unsigned SUM_WIDTH   = MULTIPLICAND_WIDTH + 1;

    typedef logic [CYCLE_WIDTH-1:0]        cycle_t;
    typedef logic [MULTIPLICAND_WIDTH-1:0] operand_t;
    typedef logic [MULTIPLIER_WIDTH-1:0]   mpl_t;
    typedef logic [SUM_WIDTH-1:0]          sum_t;
    typedef logic [SHIFT_WIDTH-1:0]        shift_t;

    if (ADDEND_WIDTH > MULTIPLICAND_WIDTH) begin : g_bad_addend_width
        $error("ADDEND_WIDTH must not exceed MULTIPLICAND_WIDTH");
    end

    mc_state_t state;
    mc_state_t next_state;
    logic      accept_c;
    logic      step_c;

    cycle_t    cycle;
    operand_t  multiplicand;
    operand_t  acc;
    mpl_t      mpl;
    sum_t      sum_c;
    shift_t    shift_c;

    // Next-state and datapath strobes.
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        step_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cke && s_valid) begin
                    accept_c   = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cke) begin
                    step_c = 1'b1;
                    if (cycle == '0) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (cke && m_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Control registers; handshake outputs follow the next state so they are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
        end else begin
            state   <= next_state;
            m_valid <= (next_state == ST_DONE);
            s_ready <= (next_state == ST_IDLE);
        end
    end

    // One shift-add step: the adder carry becomes the new acc MSB, acc LSB shifts into mpl.
    always_comb begin
        sum_c   = {1'b0, acc} + (mpl[0] ? {1'b0, multiplicand} : sum_t'(0));
        shift_c = SHIFT_WIDTH'({sum_c, mpl} >> 1);
    end

    always_ff @(posedge clk) begin
        if (accept_c) begin
            multiplicand <= s_multiplicand;
            acc          <= MULTIPLICAND_WIDTH'(s_addend);
            mpl          <= s_multiplier;
            cycle        <= CYCLE_WIDTH'(MULTIPLIER_WIDTH - 1);
        end else if (step_c) begin
            {acc, mpl}   <= shift_c;
            cycle        <= cycle - cycle_t'(1);
        end
    end

    assign m_product = PRODUCT_WIDTH'({acc, mpl});

endmodule
